// File: rtl/cfg_loader_pkg.sv
// rtl/cfg_loader_pkg.sv - shared state type and sizing helper for the configuration-chain loader
package cfg_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Width of a counter that must represent every value from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/cfg_piso.sv
// rtl/cfg_piso.sv - word register that serialises one configuration word per load
module cfg_piso
  import cfg_loader_pkg::*;
#(
  parameter int WORD_W    = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              bit_o,
  output logic              last_o,
  output logic              last_next_o
);

  localparam int IW = cnt_width(WORD_W - 1);

  logic [WORD_W-1:0] data_ord;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [IW-1:0]     idx_q, idx_d;

  // Reorder the word into shift order so the register always shifts out of its MSB.
  always_comb begin
    data_ord = '0;
    for (int i = 0; i < WORD_W; i++) begin
      data_ord[i] = (MSB_FIRST != 0) ? data_i[i] : data_i[WORD_W-1-i];
    end
  end

  // Next register contents and bit index: a load restarts the word, a shift advances it.
  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    if (load_i) begin
      sr_d  = data_ord;
      idx_d = '0;
    end else if (shift_i) begin
      sr_d  = {sr_q[WORD_W-2:0], 1'b0};
      idx_d = idx_q + IW'(1);
    end
  end

  // Word register and per-word bit index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q  <= '0;
      idx_q <= '0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
    end
  end

  // The serial bit comes straight from a flop, so it is already a registered output.
  assign bit_o       = sr_q[WORD_W-1];
  assign last_o      = (idx_q == IW'(WORD_W - 1));
  assign last_next_o = (idx_d == IW'(WORD_W - 1));

endmodule

// File: rtl/config_chain_loader.sv
// rtl/config_chain_loader.sv - clears a scan chain then shifts CHAIN_LEN configuration bits into it
module config_chain_loader
  import cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN  = 1024,
  parameter int WORD_W     = 16,
  parameter int CLR_CYCLES = 2,
  parameter int MSB_FIRST  = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic                           word_valid,
  input  logic [WORD_W-1:0]              word_data,
  output logic                           word_ready,
  output logic                           chain_d,
  output logic                           chain_en,
  output logic                           chain_rst_n,
  output logic                           busy,
  output logic                           done,
  output logic [cnt_width(CHAIN_LEN)-1:0] bits_left
);

  localparam int CW = cnt_width(CHAIN_LEN);
  localparam int TW = cnt_width(CLR_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] bits_left_q, bits_left_d;
  logic [TW-1:0] clr_cnt_q, clr_cnt_d;

  logic word_ready_q, word_ready_d;
  logic chain_en_q, chain_en_d;
  logic chain_rst_n_q, chain_rst_n_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic handshake;
  logic piso_shift;
  logic piso_bit;
  logic piso_last;
  logic piso_last_next;

  assign handshake  = word_valid && word_ready_q;
  assign piso_shift = (state_q == ST_SHIFT) && !piso_last;

  cfg_piso #(
    .WORD_W    (WORD_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk         (clk),
    .reset       (reset),
    .load_i      (handshake),
    .shift_i     (piso_shift),
    .data_i      (word_data),
    .bit_o       (piso_bit),
    .last_o      (piso_last),
    .last_next_o (piso_last_next)
  );

  // Sequencing: clear timer, word intake, shifting and bit accounting.
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    clr_cnt_d   = clr_cnt_q;
    // A bit on the chain this cycle is shifted at the edge even if the load is being aborted.
    if (state_q == ST_SHIFT) begin
      bits_left_d = bits_left_q - CW'(1);
    end
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d     = ST_CLEAR;
            bits_left_d = CW'(CHAIN_LEN);
            clr_cnt_d   = '0;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == TW'(CLR_CYCLES - 1)) begin
            state_d = ST_LOAD;
          end else begin
            clr_cnt_d = clr_cnt_q + TW'(1);
          end
        end
        ST_LOAD: begin
          if (handshake) begin
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bits_left_q == CW'(1)) begin
            state_d = ST_DONE;
          end else if (piso_last) begin
            state_d = handshake ? ST_SHIFT : ST_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output values for the coming cycle, derived from the coming state so they can be registered.
  always_comb begin
    word_ready_d  = (state_d == ST_LOAD) ||
                    ((state_d == ST_SHIFT) && piso_last_next && (bits_left_d > CW'(1)));
    chain_en_d    = (state_d == ST_SHIFT);
    chain_rst_n_d = (state_d != ST_CLEAR);
    busy_d        = (state_d == ST_CLEAR) || (state_d == ST_LOAD) || (state_d == ST_SHIFT);
    done_d        = (state_d == ST_DONE);
  end

  // State and registered outputs; chain_rst_n stays low throughout reset so the chain is cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      bits_left_q   <= CW'(CHAIN_LEN);
      clr_cnt_q     <= '0;
      word_ready_q  <= 1'b0;
      chain_en_q    <= 1'b0;
      chain_rst_n_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      bits_left_q   <= bits_left_d;
      clr_cnt_q     <= clr_cnt_d;
      word_ready_q  <= word_ready_d;
      chain_en_q    <= chain_en_d;
      chain_rst_n_q <= chain_rst_n_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign word_ready  = word_ready_q;
  assign chain_d     = piso_bit;
  assign chain_en    = chain_en_q;
  assign chain_rst_n = chain_rst_n_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign bits_left   = bits_left_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// tb/tb_config_chain_loader.sv - scoreboard bench for config_chain_loader in both bit orders
module tb_config_chain_loader;

  localparam int CL = 40;
  localparam int WW = 16;
  localparam int CC = 2;
  localparam int NW = (CL + WW - 1) / WW;
  localparam int BW = $clog2(CL + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          word_valid = 1'b0;
  logic [WW-1:0] word_data = '0;

  logic          word_ready_a, chain_d_a, chain_en_a, chain_rst_n_a, busy_a, done_a;
  logic [BW-1:0] bits_left_a;
  logic          word_ready_b, chain_d_b, chain_en_b, chain_rst_n_b, busy_b, done_b;
  logic [BW-1:0] bits_left_b;

  always #5 clk = ~clk;

  config_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CLR_CYCLES(CC), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready_a),
    .chain_d(chain_d_a), .chain_en(chain_en_a), .chain_rst_n(chain_rst_n_a),
    .busy(busy_a), .done(done_a), .bits_left(bits_left_a)
  );

  config_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CLR_CYCLES(CC), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready_b),
    .chain_d(chain_d_b), .chain_en(chain_en_b), .chain_rst_n(chain_rst_n_b),
    .busy(busy_b), .done(done_b), .bits_left(bits_left_b)
  );

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;
  int seen   = 0;
  bit exp_a[$];
  bit exp_b[$];
  logic [WW-1:0] words [NW];
  logic [WW-1:0] fixed_tab [NW] = '{16'hA5C3, 16'h0F0F, 16'hFF00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference stream: words concatenated in shift order, truncated to the chain length.
  task automatic plan_words(input bit fixed);
    exp_a.delete();
    exp_b.delete();
    for (int w = 0; w < NW; w++) begin
      words[w] = fixed ? fixed_tab[w] : WW'($urandom);
      for (int k = 0; k < WW; k++) begin
        if (w * WW + k < CL) begin
          exp_a.push_back(words[w][WW-1-k]);
          exp_b.push_back(words[w][k]);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_word_ready"}, word_ready_a, 0);
    chk({tag, "_chain_d"}, chain_d_a, 0);
    chk({tag, "_chain_en"}, chain_en_a, 0);
    chk({tag, "_chain_rst_n"}, chain_rst_n_a, 0);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 0);
    chk({tag, "_bits_left"}, bits_left_a, CL);
    chk({tag, "_b_ready_en_rst"}, {word_ready_b, chain_en_b, chain_rst_n_b, busy_b}, 0);
  endtask

  // Source: mode 0 holds valid, mode 1 drops valid for 5 cycles when the 2nd word is wanted, mode 2 random.
  task automatic drive_word(input int mode, input int cyc, input int widx);
    bit v;
    if (widx >= NW) v = 1'b0;
    else if (mode == 1) v = !(cyc >= CC + 1 + WW && cyc <= CC + WW + 5);
    else if (mode == 2) v = ($urandom_range(0, 2) != 0);
    else v = 1'b1;
    word_valid = v;
    if (v) word_data = words[widx];
    else word_data = WW'($urandom);
  endtask

  task automatic run_load(input int mode);
    int c = 0;
    int widx = 0;
    int done_cyc = -1;
    bit rdy_prev;
    plan_words(mode != 2);
    seen = 0;
    @(negedge clk);
    start = 1'b1;
    drive_word(mode, 0, widx);
    rdy_prev = word_ready_a;
    while (done_cyc < 0 && c < 300) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        start  = 1'b0;
        mon_on = 1'b1;
        chk("bits_left_reload", bits_left_a, CL);
      end
      if (mode == 0) begin
        chk("tbl_chain_rst_n", chain_rst_n_a, !(c >= 1 && c <= CC));
        chk("tbl_word_ready", word_ready_a,
            (c == CC + 1) || (c == CC + 1 + WW) || (c == CC + 1 + 2 * WW));
        chk("tbl_chain_en", chain_en_a, (c >= CC + 2) && (c <= CC + 1 + CL));
        chk("tbl_done", done_a, c >= CC + 2 + CL);
        chk("tbl_busy", busy_a, c <= CC + 1 + CL);
      end
      if (mode == 1 && c >= CC + 2 + WW && c <= CC + 6 + WW) begin
        chk("underflow_chain_en", chain_en_a, 0);
        chk("underflow_bits_left", bits_left_a, CL - WW);
      end
      if (done_a) done_cyc = c;
      if (word_valid && rdy_prev) widx++;
      drive_word(mode, c, widx);
      rdy_prev = word_ready_a;
    end
    chk("done_reached", done_cyc >= 0, 1);
    if (mode == 0) chk("done_cycle", done_cyc, CC + 2 + CL);
    if (mode == 1) chk("done_cycle_gap", done_cyc, CC + 7 + CL);
    chk("bits_shifted", seen, CL);
    chk("stream_consumed", exp_a.size(), 0);
    chk("bits_left_end", bits_left_a, 0);
    chk("done_b", done_b, 1);
    chk("bits_left_end_b", bits_left_b, 0);
    mon_on = 1'b0;
    word_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("done_held", done_a, 1);
    chk("busy_after_done", busy_a, 0);
  endtask

  // Monitor: every enabled chain bit is popped from the reference stream and compared.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("bits_left_track", bits_left_a, CL - seen);
      if (chain_en_a) begin
        chk("bit_available", (exp_a.size() > 0) && (exp_b.size() > 0), 1);
        if (exp_a.size() > 0 && exp_b.size() > 0) begin
          chk("chain_d_msb_first", chain_d_a, exp_a.pop_front());
          chk("chain_d_lsb_first", chain_d_b, exp_b.pop_front());
        end
        seen++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    reset = 1'b1;
    @(negedge clk);
    chk("post_reset_chain_rst_n", chain_rst_n_a, 1);
    chk("post_reset_busy", busy_a, 0);
    chk("post_reset_bits_left", bits_left_a, CL);

    run_load(0);
    run_load(1);
    for (int i = 0; i < 4; i++) run_load(2);

    // Abort together with start in the middle of shifting.
    plan_words(1'b0);
    @(negedge clk);
    start = 1'b1;
    word_valid = 1'b1;
    word_data = words[0];
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      word_data = WW'($urandom);
      if (c == 10) begin
        chk("abort_pre_chain_en", chain_en_a, 1);
        start = 1'b1;
        abort = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    word_valid = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_chain_en", chain_en_a, 0);
    chk("abort_word_ready", word_ready_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_chain_rst_n", chain_rst_n_a, 1);
    chk("abort_bits_left_partial", bits_left_a < CL, 1);
    repeat (2) @(negedge clk);
    chk("abort_stays_idle", busy_a, 0);
    run_load(2);

    // Asynchronous reset in the middle of a load.
    plan_words(1'b0);
    @(negedge clk);
    start = 1'b1;
    word_valid = 1'b1;
    word_data = words[0];
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    chk("pre_reset_busy", busy_a, 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("async");
    @(posedge clk);
    #1;
    chk("reset_hold_chain_rst_n", chain_rst_n_a, 0);
    chk("reset_hold_chain_en", chain_en_a, 0);
    word_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_release_chain_rst_n", chain_rst_n_a, 1);
    chk("reset_release_busy", busy_a, 0);
    run_load(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
